pm_stage: RTL and testbench

PM_STAGE -- requirements
Module: pm_stage

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/load_align.sv | 44 ++++
 rtl/pm_stage.sv | 139 +++++++++++++
 tb/tb_pm_stage.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU encodings: op-bundle field positions, load kinds and pm-stage entry states.
package cpu_pkg;
  localparam int OP_W     = 20;
  localparam int SAVE_HI  = 9;
  localparam int SAVE_LO  = 7;
  localparam int LOAD_HI  = 6;
  localparam int LOAD_LO  = 4;
  localparam int EXC_FLAG = 6;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_LW   = 3'b001,
    LD_LWL  = 3'b010,
    LD_LWR  = 3'b011,
    LD_LB   = 3'b100,
    LD_LH   = 3'b101,
    LD_LBU  = 3'b110,
    LD_LHU  = 3'b111
  } load_e;

  typedef enum logic [1:0] {
    PM_IDLE,
    PM_WAIT,
    PM_DONE
  } pm_state_e;

  // Only exception-free memory ops get a response from the data bus.
  function automatic logic needs_resp(input logic [OP_W-1:0] op, input logic [6:0] exc);
    return ((op[LOAD_HI:LOAD_LO] != 3'b000) || (op[SAVE_HI:SAVE_LO] != 3'b000)) && !exc[EXC_FLAG];
  endfunction
endpackage

// File: rtl/load_align.sv
// Load result formatting: byte/halfword extraction and LWL/LWR merge with the old rt value.
module load_align
  import cpu_pkg::*;
(
  input  load_e       load_op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] old_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    result_o = rdata_i;
    unique case (load_op_i)
      LD_LB:  result_o = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU: result_o = {24'h0, byte_sel};
      LD_LH:  result_o = {{16{half_sel[15]}}, half_sel};
      LD_LHU: result_o = {16'h0, half_sel};
      LD_LWL: begin
        unique case (addr_i)
          2'd0:    result_o = {rdata_i[7:0],  old_i[23:0]};
          2'd1:    result_o = {rdata_i[15:0], old_i[15:0]};
          2'd2:    result_o = {rdata_i[23:0], old_i[7:0]};
          default: result_o = rdata_i;
        endcase
      end
      LD_LWR: begin
        unique case (addr_i)
          2'd0:    result_o = rdata_i;
          2'd1:    result_o = {old_i[31:24], rdata_i[31:8]};
          2'd2:    result_o = {old_i[31:16], rdata_i[31:16]};
          default: result_o = {old_i[31:8],  rdata_i[31:24]};
        endcase
      end
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/pm_stage.sv
// Pipeline stage that waits for in-order data-bus responses, formats loads and
// silently discards responses belonging to flushed instructions.
module pm_stage
  import cpu_pkg::*;
#(
  parameter int DISC_W = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              exe_to_pm_valid,
  output logic              pm_allowin,
  input  logic [31:0]       exe_pc,
  input  logic [OP_W-1:0]   exe_out_op,
  input  logic [4:0]        exe_dest,
  input  logic [31:0]       exe_value,
  input  logic [31:0]       exe_ld_value,
  input  logic [6:0]        exe_exc,
  input  logic [31:0]       exe_badvaddr,
  input  logic [31:0]       data_rdata,
  input  logic              data_data_ok,
  input  logic              ctrl_pm_disable,
  output logic              pm_valid,
  output logic              pm_to_mem_valid,
  input  logic              mem_allowin,
  output logic [31:0]       pm_pc,
  output logic [OP_W-1:0]   pm_out_op,
  output logic [4:0]        pm_dest,
  output logic [31:0]       pm_value,
  output logic [6:0]        pm_exc,
  output logic [31:0]       pm_badvaddr
);

  localparam logic [DISC_W-1:0] DISC_MAX = '1;

  logic              valid_q, valid_d;
  pm_state_e         state_q, state_d;
  logic [DISC_W-1:0] disc_q, disc_d;
  logic [31:0]       pc_q, value_q, ld_value_q, badvaddr_q, rdata_q;
  logic [OP_W-1:0]   op_q;
  logic [4:0]        dest_q;
  logic [6:0]        exc_q;
  logic              need_resp_q;

  logic        accept, transfer, resp_drop, resp_take, disc_inc;
  load_e       ld_op;
  logic [31:0] aligned;

  assign pm_valid        = valid_q;
  assign pm_to_mem_valid = valid_q && (state_q == PM_DONE) && !ctrl_pm_disable;
  assign transfer        = pm_to_mem_valid && mem_allowin;
  assign pm_allowin      = !valid_q || transfer || ctrl_pm_disable;
  assign accept          = exe_to_pm_valid && pm_allowin;

  // A pending discard always claims the response before any waiting entry can.
  assign resp_drop = data_data_ok && (disc_q != '0);
  assign resp_take = data_data_ok && (disc_q == '0) && valid_q && (state_q == PM_WAIT) && !ctrl_pm_disable;
  assign disc_inc  = ctrl_pm_disable && valid_q && (state_q == PM_WAIT) && !(data_data_ok && (disc_q == '0));

  always_comb begin
    valid_d = valid_q;
    state_d = state_q;
    disc_d  = disc_q;
    if (accept) begin
      valid_d = 1'b1;
      state_d = needs_resp(exe_out_op, exe_exc) ? PM_WAIT : PM_DONE;
    end else if (transfer || ctrl_pm_disable) begin
      valid_d = 1'b0;
      state_d = PM_IDLE;
    end else if (resp_take) begin
      state_d = PM_DONE;
    end
    if (disc_inc && !resp_drop) begin
      if (disc_q != DISC_MAX) disc_d = disc_q + 1'b1;
    end else if (resp_drop && !disc_inc) begin
      disc_d = disc_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      state_q <= PM_IDLE;
      disc_q  <= '0;
    end else begin
      valid_q <= valid_d;
      state_q <= state_d;
      disc_q  <= disc_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q        <= RESET_PC;
      op_q        <= '0;
      dest_q      <= '0;
      value_q     <= '0;
      ld_value_q  <= '0;
      exc_q       <= '0;
      badvaddr_q  <= '0;
      need_resp_q <= 1'b0;
    end else if (accept) begin
      pc_q        <= exe_pc;
      op_q        <= exe_out_op;
      dest_q      <= exe_dest;
      value_q     <= exe_value;
      ld_value_q  <= exe_ld_value;
      exc_q       <= exe_exc;
      badvaddr_q  <= exe_badvaddr;
      need_resp_q <= needs_resp(exe_out_op, exe_exc);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdata_q <= '0;
    else if (resp_take) rdata_q <= data_rdata;
  end

  assign ld_op = load_e'(op_q[LOAD_HI:LOAD_LO]);

  load_align u_load_align (
    .load_op_i (ld_op),
    .addr_i    (value_q[1:0]),
    .rdata_i   (rdata_q),
    .old_i     (ld_value_q),
    .result_o  (aligned)
  );

  assign pm_pc       = pc_q;
  assign pm_out_op   = op_q;
  assign pm_dest     = dest_q;
  assign pm_exc      = exc_q;
  assign pm_badvaddr = badvaddr_q;
  assign pm_value    = ((state_q == PM_DONE) && need_resp_q && (ld_op != LD_NONE)) ? aligned : value_q;

  // More flushed responses in flight than the counter can hold is a bus protocol error.
  assert property (@(posedge clk) disable iff (!resetn)
    !(disc_inc && !resp_drop && (disc_q == DISC_MAX)));

endmodule

// File: tb/tb_pm_stage.sv
// Directed bench for pm_stage: a response-queue model checked every cycle plus literal spot checks.
module tb_pm_stage;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        exe_to_pm_valid = 1'b0;
  logic        pm_allowin;
  logic [31:0] exe_pc = '0;
  logic [19:0] exe_out_op = '0;
  logic [4:0]  exe_dest = '0;
  logic [31:0] exe_value = '0;
  logic [31:0] exe_ld_value = '0;
  logic [6:0]  exe_exc = '0;
  logic [31:0] exe_badvaddr = '0;
  logic [31:0] data_rdata = '0;
  logic        data_data_ok = 1'b0;
  logic        ctrl_pm_disable = 1'b0;
  logic        pm_valid, pm_to_mem_valid;
  logic        mem_allowin = 1'b1;
  logic [31:0] pm_pc, pm_value, pm_badvaddr;
  logic [19:0] pm_out_op;
  logic [4:0]  pm_dest;
  logic [6:0]  pm_exc;

  pm_stage #(.DISC_W(2)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .exe_to_pm_valid (exe_to_pm_valid),
    .pm_allowin      (pm_allowin),
    .exe_pc          (exe_pc),
    .exe_out_op      (exe_out_op),
    .exe_dest        (exe_dest),
    .exe_value       (exe_value),
    .exe_ld_value    (exe_ld_value),
    .exe_exc         (exe_exc),
    .exe_badvaddr    (exe_badvaddr),
    .data_rdata      (data_rdata),
    .data_data_ok    (data_data_ok),
    .ctrl_pm_disable (ctrl_pm_disable),
    .pm_valid        (pm_valid),
    .pm_to_mem_valid (pm_to_mem_valid),
    .mem_allowin     (mem_allowin),
    .pm_pc           (pm_pc),
    .pm_out_op       (pm_out_op),
    .pm_dest         (pm_dest),
    .pm_value        (pm_value),
    .pm_exc          (pm_exc),
    .pm_badvaddr     (pm_badvaddr)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;
  int xferCount = 0;
  logic checkEn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Load result from plain shift/mask arithmetic on the byte address.
  function automatic logic [31:0] modelLoad(input logic [2:0] ld, input logic [31:0] addr,
                                            input logic [31:0] old, input logic [31:0] rd);
    int a;
    logic [31:0] b, h;
    logic [63:0] keep;
    a = int'(addr % 4);
    b = (rd >> (8 * a)) & 32'hff;
    h = (rd >> (16 * (a / 2))) & 32'hffff;
    case (ld)
      3'b001: return rd;
      3'b100: return b + ((b >= 32'd128) ? 32'hffffff00 : 32'h0);
      3'b110: return b;
      3'b101: return h + ((h >= 32'd32768) ? 32'hffff0000 : 32'h0);
      3'b111: return h;
      3'b010: begin
        keep = 64'hffffffff >> (8 * (a + 1));
        return (rd << (8 * (3 - a))) | (old & keep[31:0]);
      end
      3'b011: return (rd >> (8 * a)) | (old & ~(32'hffffffff >> (8 * a)));
      default: return addr;
    endcase
  endfunction

  logic        mValid = 1'b0, mDone = 1'b0, mNeed = 1'b0;
  logic [31:0] mPc = 32'hbfc00000, mValue = '0, mOld = '0, mBad = '0, mRd = '0;
  logic [19:0] mOp = '0;
  logic [4:0]  mDest = '0;
  logic [6:0]  mExc = '0;
  bit          tokQ[$];

  // Every response-needing entry queues a token; flushing a waiting entry kills its token,
  // and responses pop tokens in order, so only a live token can complete the held entry.
  always @(posedge clk or negedge resetn) begin
    bit tv, allow, live;
    if (!resetn) begin
      mValid = 0; mDone = 0; mNeed = 0; mPc = 32'hbfc00000; mValue = 0; mOld = 0;
      mBad = 0; mRd = 0; mOp = 0; mDest = 0; mExc = 0;
      tokQ.delete();
    end else begin
      tv = mValid && mDone && !ctrl_pm_disable;
      allow = !mValid || (tv && mem_allowin) || ctrl_pm_disable;
      live = 0;
      if (data_data_ok && tokQ.size() > 0) live = tokQ.pop_front();
      if (live && !ctrl_pm_disable) begin
        mDone = 1;
        mRd = data_rdata;
      end
      if (ctrl_pm_disable && mValid && !mDone && !live)
        foreach (tokQ[i]) tokQ[i] = 0;
      if (exe_to_pm_valid && allow) begin
        mValid = 1;
        mPc = exe_pc; mOp = exe_out_op; mDest = exe_dest; mValue = exe_value;
        mOld = exe_ld_value; mExc = exe_exc; mBad = exe_badvaddr;
        mNeed = ((exe_out_op[6:4] != 0) || (exe_out_op[9:7] != 0)) && !exe_exc[6];
        mDone = !mNeed;
        if (mNeed) tokQ.push_back(1);
      end else if (ctrl_pm_disable || (tv && mem_allowin)) begin
        mValid = 0;
      end
    end
  end

  // Per-cycle comparison against the model, half a period away from the active edge.
  always @(negedge clk) begin : compare
    logic eTv, eAllow;
    if (resetn && checkEn) begin
      eTv = mValid && mDone && !ctrl_pm_disable;
      eAllow = !mValid || (eTv && mem_allowin) || ctrl_pm_disable;
      checkOutput("pm_valid", pm_valid, mValid);
      checkOutput("pm_to_mem_valid", pm_to_mem_valid, eTv);
      checkOutput("pm_allowin", pm_allowin, eAllow);
      if (mValid) begin
        checkOutput("pm_pc", pm_pc, mPc);
        checkOutput("pm_out_op", pm_out_op, mOp);
        checkOutput("pm_dest", pm_dest, mDest);
        checkOutput("pm_exc", pm_exc, mExc);
        checkOutput("pm_badvaddr", pm_badvaddr, mBad);
        if (mDone)
          checkOutput("pm_value", pm_value,
                      (mNeed && mOp[6:4] != 0) ? modelLoad(mOp[6:4], mValue, mOld, mRd) : mValue);
      end
      if (pm_to_mem_valid && mem_allowin) xferCount++;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] ld, input logic [2:0] sv, input logic [31:0] pc,
                               input logic [31:0] value, input logic [31:0] old,
                               input logic [6:0] exc, input logic [31:0] bad);
    exe_to_pm_valid = 1'b1;
    exe_pc = pc;
    exe_out_op = {pc[11:2], sv, ld, 4'hA};
    exe_dest = pc[6:2];
    exe_value = value;
    exe_ld_value = old;
    exe_exc = exc;
    exe_badvaddr = bad;
  endtask

  task automatic idle();
    exe_to_pm_valid = 1'b0;
  endtask

  task automatic resp(input logic [31:0] rd);
    data_data_ok = 1'b1;
    data_rdata = rd;
    step();
    data_data_ok = 1'b0;
  endtask

  task automatic runLoad(input string name, input logic [2:0] ld, input logic [31:0] addr,
                         input logic [31:0] old, input logic [31:0] rd, input logic [31:0] expVal);
    applyStimulus(ld, 3'b000, 32'h0040_0100 + addr, addr, old, 7'h0, 32'h0);
    step();
    idle();
    @(negedge clk);
    checkOutput({name, " waiting"}, pm_to_mem_valid, 1'b0);
    step();
    resp(rd);
    @(negedge clk);
    checkOutput(name, pm_value, expVal);
    checkOutput({name, " ready"}, pm_to_mem_valid, 1'b1);
    step();
  endtask

  initial begin
    int base;
    #12;
    checkOutput("reset pm_valid", pm_valid, 1'b0);
    checkOutput("reset pm_to_mem_valid", pm_to_mem_valid, 1'b0);
    checkOutput("reset pm_pc", pm_pc, 32'hbfc00000);
    checkOutput("reset pm_value", pm_value, 32'h0);
    checkOutput("reset pm_allowin", pm_allowin, 1'b1);
    resetn = 1'b1;
    checkEn = 1'b1;
    step();

    runLoad("LB a3", 3'b100, 32'h1000_0003, 32'hDEAD_BEEF, 32'h80FF_FFFF, 32'hFFFF_FF80);
    runLoad("LBU a3", 3'b110, 32'h1000_0003, 32'hDEAD_BEEF, 32'h80FF_FFFF, 32'h0000_0080);
    runLoad("LWL a1", 3'b010, 32'h1000_0001, 32'h1122_3344, 32'hAABB_CCDD, 32'hCCDD_3344);
    runLoad("LWR a1", 3'b011, 32'h1000_0001, 32'h1122_3344, 32'hAABB_CCDD, 32'h11AA_BBCC);
    runLoad("LWL a0", 3'b010, 32'h1000_0000, 32'h1122_3344, 32'hAABB_CCDD, 32'hDD22_3344);
    runLoad("LWL a3", 3'b010, 32'h1000_0003, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CCDD);
    runLoad("LWR a3", 3'b011, 32'h1000_0003, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_33AA);
    runLoad("LW", 3'b001, 32'h1000_0004, 32'h0, 32'h1234_5678, 32'h1234_5678);
    runLoad("LH a0", 3'b101, 32'h1000_0000, 32'h0, 32'h1234_8765, 32'hFFFF_8765);
    runLoad("LHU a2", 3'b111, 32'h1000_0002, 32'h0, 32'h8765_1234, 32'h0000_8765);
    runLoad("LB a1", 3'b100, 32'h1000_0001, 32'h0, 32'h0000_7F00, 32'h0000_007F);

    // Store waits for its response but passes the address through.
    applyStimulus(3'b000, 3'b011, 32'h0040_0200, 32'h2000_0010, 32'h0, 7'h0, 32'h0);
    step(); idle();
    resp(32'h5555_5555);
    @(negedge clk);
    checkOutput("store value", pm_value, 32'h2000_0010);
    step();

    // Back-to-back ALU results flow without waiting.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b000, 3'b000, 32'h0040_0300 + 4 * i, 32'h0000_1234 + i, 32'h0, 7'h0, 32'h0);
      step();
    end
    idle();
    @(negedge clk);
    checkOutput("alu last value", pm_value, 32'h0000_1236);
    step();

    // Late response and downstream stall.
    applyStimulus(3'b001, 3'b000, 32'h0040_0400, 32'h0000_0200, 32'h0, 7'h0, 32'h0);
    step(); idle();
    step(2);
    data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; mem_allowin = 1'b0;
    step();
    data_data_ok = 1'b0;
    base = xferCount;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("stall held", pm_to_mem_valid, 1'b1);
      checkOutput("stall value", pm_value, 32'hCAFE_F00D);
      step();
    end
    mem_allowin = 1'b1;
    step();
    @(negedge clk);
    checkOutput("stall drained", pm_valid, 1'b0);
    checkOutput("stall one transfer", xferCount - base, 1);
    step();

    // Flush in WAIT: the stale response is dropped, the next one completes the new load.
    applyStimulus(3'b001, 3'b000, 32'h0040_0500, 32'h0000_0300, 32'h0, 7'h0, 32'h0);
    step(); idle();
    ctrl_pm_disable = 1'b1; step(); ctrl_pm_disable = 1'b0;
    applyStimulus(3'b101, 3'b000, 32'h0040_0504, 32'h0000_0302, 32'h0, 7'h0, 32'h0);
    step(); idle();
    resp(32'hDEAD_DEAD);
    @(negedge clk);
    checkOutput("flush stale dropped", pm_to_mem_valid, 1'b0);
    step();
    resp(32'h8001_2345);
    @(negedge clk);
    checkOutput("flush new load", pm_value, 32'hFFFF_8001);
    step();

    // Two flushed loads outstanding ahead of a third.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(3'b001, 3'b000, 32'h0040_0600 + 4 * i, 32'h0000_0400, 32'h0, 7'h0, 32'h0);
      step(); idle();
      ctrl_pm_disable = 1'b1; step(); ctrl_pm_disable = 1'b0;
    end
    applyStimulus(3'b110, 3'b000, 32'h0040_0608, 32'h0000_0402, 32'h0, 7'h0, 32'h0);
    step(); idle();
    resp(32'h1111_1111);
    resp(32'h2222_2222);
    @(negedge clk);
    checkOutput("double flush dropped", pm_to_mem_valid, 1'b0);
    step();
    resp(32'h00AB_0000);
    @(negedge clk);
    checkOutput("double flush load", pm_value, 32'h0000_00AB);
    step();

    // Flush coinciding with the entry's own response: nothing left to discard.
    applyStimulus(3'b001, 3'b000, 32'h0040_0700, 32'h0000_0500, 32'h0, 7'h0, 32'h0);
    step(); idle();
    ctrl_pm_disable = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
    step();
    ctrl_pm_disable = 1'b0; data_data_ok = 1'b0;
    applyStimulus(3'b001, 3'b000, 32'h0040_0704, 32'h0000_0504, 32'h0, 7'h0, 32'h0);
    step(); idle();
    resp(32'h1357_9BDF);
    @(negedge clk);
    checkOutput("flush+resp next load", pm_value, 32'h1357_9BDF);
    step();

    // Excepting load skips the memory wait.
    applyStimulus(3'b001, 3'b000, 32'h0040_0800, 32'h0000_0101, 32'h0, 7'b10_00100, 32'h0000_0101);
    step(); idle();
    @(negedge clk);
    checkOutput("exc ready", pm_to_mem_valid, 1'b1);
    checkOutput("exc badvaddr", pm_badvaddr, 32'h0000_0101);
    checkOutput("exc value", pm_value, 32'h0000_0101);
    step();

    // Reset while waiting, then a fresh load needs exactly one response.
    applyStimulus(3'b001, 3'b000, 32'h0040_0900, 32'h0000_0600, 32'h0, 7'h0, 32'h0);
    step(); idle();
    #2 resetn = 1'b0;
    #1;
    checkOutput("midreset pm_valid", pm_valid, 1'b0);
    checkOutput("midreset pm_pc", pm_pc, 32'hbfc00000);
    checkOutput("midreset pm_allowin", pm_allowin, 1'b1);
    #1 resetn = 1'b1;
    step();
    applyStimulus(3'b001, 3'b000, 32'h0040_0A00, 32'h0000_0700, 32'h0, 7'h0, 32'h0);
    step(); idle();
    resp(32'h2468_ACE0);
    @(negedge clk);
    checkOutput("post reset load", pm_value, 32'h2468_ACE0);
    checkOutput("post reset ready", pm_to_mem_valid, 1'b1);
    step(3);

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
